// File: rtl/tex_flash_read_arbiter.sv
// Two-requester round-robin arbiter for the shared SPI-flash texture port; each grant runs one single-bit read.
// Optional feature macro TEX_FAST_READ_EN: opcode 0x0B with 8 dummy bit-times between address and data.
module tex_flash_read_arbiter #(
  parameter int         DATA_BITS       = 24,
  parameter int         CSB_HIGH_CYCLES = 2,
  parameter logic [7:0] READ_CMD        = 8'h03
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           i_req,
  input  logic [23:0]          i_addr0,
  input  logic [23:0]          i_addr1,
  output logic [1:0]           o_ack,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_data_valid,
  output logic                 o_data_id,
  output logic                 o_busy,
  output logic                 o_tex_csb,
  output logic                 o_tex_sclk,
  output logic                 o_tex_out0,
  output logic                 o_tex_oeb0,
  input  logic [3:0]           i_tex_in
);

`ifdef TEX_FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
`else
  localparam logic [7:0] OPCODE = READ_CMD;
`endif

  typedef enum logic [2:0] {IDLE, START, CMD, ADDR, DUMMY, DATA, STOP} state_t;

  state_t               state, state_n;
  logic                 ph, ph_n;
  logic [15:0]          cnt, cnt_n;
  logic [31:0]          tx, tx_n;
  logic [DATA_BITS-1:0] rx, rx_n, rx_shift, data_n;
  logic                 rr, rr_n, id, id_n;
  logic [1:0]           ack_n;
  logic                 valid_n, data_id_n, busy_n;
  logic                 csb_n, sclk_n, out0_n, oeb0_n;
  logic                 arb_en, gid;

  // io0/io2/io3 inputs carry nothing for a single-bit read
  logic unused_tex_in;
  assign unused_tex_in = ^{i_tex_in[3:2], i_tex_in[0]};

  always_comb begin
    state_n   = state;
    ph_n      = ph;
    cnt_n     = cnt;
    tx_n      = tx;
    rx_n      = rx;
    rr_n      = rr;
    id_n      = id;
    ack_n     = 2'b00;
    data_n    = o_data;
    valid_n   = 1'b0;
    data_id_n = o_data_id;
    csb_n     = o_tex_csb;
    sclk_n    = o_tex_sclk;
    out0_n    = o_tex_out0;
    oeb0_n    = o_tex_oeb0;
    arb_en    = 1'b0;
    rx_shift  = (rx << 1) | DATA_BITS'(i_tex_in[1]);
    gid       = (i_req == 2'b11) ? rr : i_req[1];

    case (state)
      IDLE: begin
        // A pending ack means the grant was already taken; start the frame
        if (o_ack != 2'b00) begin
          state_n = START;
          csb_n   = 1'b0;
          sclk_n  = 1'b0;
          oeb0_n  = 1'b0;
          out0_n  = tx[31];
          ph_n    = 1'b0;
          cnt_n   = 16'd7;
        end else begin
          arb_en = 1'b1;
        end
      end
      START: begin
        state_n = CMD;
        sclk_n  = 1'b1;
        ph_n    = 1'b1;
      end
      CMD, ADDR, DUMMY, DATA: begin
        if (!ph) begin
          sclk_n = 1'b1;
          ph_n   = 1'b1;
        end else begin
          sclk_n = 1'b0;
          ph_n   = 1'b0;
          cnt_n  = cnt - 16'd1;
          if (state == CMD || state == ADDR) begin
            tx_n   = tx << 1;
            out0_n = tx[30];
          end
          if (state == DATA) rx_n = rx_shift;
          if (cnt == 16'd0) begin
            if (state == CMD) begin
              state_n = ADDR;
              cnt_n   = 16'd23;
            end else if (state == ADDR) begin
              oeb0_n = 1'b1;
              out0_n = 1'b0;
`ifdef TEX_FAST_READ_EN
              state_n = DUMMY;
              cnt_n   = 16'd7;
`else
              state_n = DATA;
              cnt_n   = 16'(DATA_BITS - 1);
`endif
            end else if (state == DUMMY) begin
              state_n = DATA;
              cnt_n   = 16'(DATA_BITS - 1);
            end else begin
              state_n   = STOP;
              csb_n     = 1'b1;
              data_n    = rx_shift;
              valid_n   = 1'b1;
              data_id_n = id;
              cnt_n     = 16'(CSB_HIGH_CYCLES - 1);
            end
          end
        end
      end
      STOP: begin
        // Arbitrating in the last high cycle lets the next ack land in the first IDLE cycle
        if (cnt == 16'd0) begin
          state_n = IDLE;
          arb_en  = 1'b1;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (arb_en && i_req != 2'b00) begin
      ack_n[gid] = 1'b1;
      rr_n       = ~gid;
      id_n       = gid;
      tx_n       = {OPCODE, gid ? i_addr1 : i_addr0};
    end
    busy_n = (state_n != IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ph           <= 1'b0;
      cnt          <= 16'd0;
      rr           <= 1'b0;
      o_ack        <= 2'b00;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_data_id    <= 1'b0;
      o_busy       <= 1'b0;
      o_tex_csb    <= 1'b1;
      o_tex_sclk   <= 1'b0;
      o_tex_out0   <= 1'b0;
      o_tex_oeb0   <= 1'b1;
    end else begin
      state        <= state_n;
      ph           <= ph_n;
      cnt          <= cnt_n;
      rr           <= rr_n;
      o_ack        <= ack_n;
      o_data       <= data_n;
      o_data_valid <= valid_n;
      o_data_id    <= data_id_n;
      o_busy       <= busy_n;
      o_tex_csb    <= csb_n;
      o_tex_sclk   <= sclk_n;
      o_tex_out0   <= out0_n;
      o_tex_oeb0   <= oeb0_n;
    end
  end

  // Shift datapath; contents are fully overwritten by every transaction
  always_ff @(posedge clk) begin
    tx <= tx_n;
    rx <= rx_n;
    id <= id_n;
  end

endmodule

// File: tb/tb_tex_flash_read_arbiter.sv
// Directed bench for tex_flash_read_arbiter with a behavioural single-bit SPI flash.
module tb_tex_flash_read_arbiter;
  localparam int DB = 24;
`ifdef TEX_FAST_READ_EN
  localparam logic [7:0] OPC = 8'h0B;
  localparam int DUM = 8;
  localparam int LAT = 129;
`else
  localparam logic [7:0] OPC = 8'h03;
  localparam int DUM = 0;
  localparam int LAT = 113;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    i_req = 2'b00;
  logic [23:0]   i_addr0 = 24'h0;
  logic [23:0]   i_addr1 = 24'h0;
  logic [1:0]    o_ack;
  logic [DB-1:0] o_data;
  logic          o_data_valid, o_data_id, o_busy;
  logic          o_tex_csb, o_tex_sclk, o_tex_out0, o_tex_oeb0;
  logic [3:0]    i_tex_in;

  int checks = 0;
  int errors = 0;
  int edges = 0;
  logic [31:0] mosi_sr = 32'h0;
  logic        miso;
  logic [23:0] w;
  logic [4:0]  idx;
  int viol = 0, valid_cnt = 0, ack1_cnt = 0, run = 0, min_run = 1000;

  always #5 clk = ~clk;

  tex_flash_read_arbiter dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr0(i_addr0), .i_addr1(i_addr1),
    .o_ack(o_ack), .o_data(o_data), .o_data_valid(o_data_valid), .o_data_id(o_data_id),
    .o_busy(o_busy), .o_tex_csb(o_tex_csb), .o_tex_sclk(o_tex_sclk),
    .o_tex_out0(o_tex_out0), .o_tex_oeb0(o_tex_oeb0), .i_tex_in(i_tex_in)
  );

  // Flash contents: one special word, otherwise the inverted address
  function automatic logic [23:0] word_for(input logic [23:0] a);
    return (a == 24'h012345) ? 24'hA5C33C : ~a;
  endfunction

  always @(posedge o_tex_sclk or posedge o_tex_csb) begin
    if (o_tex_csb) edges <= 0;
    else begin
      edges <= edges + 1;
      if (edges < 32) mosi_sr <= {mosi_sr[30:0], o_tex_out0};
    end
  end

  always_comb begin
    miso = 1'b0;
    w    = word_for(mosi_sr[23:0]);
    idx  = 5'(DB - (edges - 32 - DUM));
    if (edges > 32 + DUM && edges <= 32 + DUM + DB) miso = w[idx];
  end
  assign i_tex_in = {1'b1, 1'b0, miso, 1'b1};

  always @(negedge clk) begin
    if (o_tex_csb && o_tex_sclk) viol <= viol + 1;
    if (o_data_valid) valid_cnt <= valid_cnt + 1;
    if (o_ack[1]) ack1_cnt <= ack1_cnt + 1;
    if (o_tex_csb) run <= run + 1;
    else begin
      if (run > 0 && run < min_run) min_run <= run;
      run <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output logic [1:0] a, output int n);
    n = 0;
    a = 2'b00;
    while (n < 400) begin
      step(1);
      n++;
      if (o_ack != 2'b00) begin
        a = o_ack;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout: observed no ack, expected one within 400 cycles");
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 400) begin
      step(1);
      n++;
      if (o_data_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL valid_timeout: observed no o_data_valid, expected one within 400 cycles");
  endtask

  initial begin
    logic [1:0] a;
    int n, vc, a1;

    // Reset state
    step(2);
    check("rst_csb", 64'(o_tex_csb), 64'(1'b1));
    check("rst_sclk_out0", 64'({o_tex_sclk, o_tex_out0}), 64'(2'b00));
    check("rst_oeb0", 64'(o_tex_oeb0), 64'(1'b1));
    check("rst_ack", 64'(o_ack), 64'(2'b00));
    check("rst_data", 64'({o_data, o_data_valid, o_data_id, o_busy}), 64'(0));
    reset = 1'b0;
    step(1);

    // Single renderer read
    i_addr0 = 24'h012345;
    i_req   = 2'b01;
    step(1);
    check("t1_ack", 64'(o_ack), 64'(2'b01));
    i_req = 2'b00;
    step(1);
    check("t1_ack_pulse", 64'(o_ack), 64'(2'b00));
    check("t1_start_pins", 64'({o_tex_csb, o_tex_sclk, o_tex_oeb0, o_tex_out0}), 64'(4'b0000));
    step(1);
    check("t1_cmd_h7", 64'({o_tex_csb, o_tex_sclk, o_tex_oeb0}), 64'(3'b010));
    step(68 + 2 * DUM);
    check("t1_data_pins", 64'({o_tex_csb, o_tex_oeb0, o_tex_out0, o_busy}), 64'(4'b0101));
    wait_valid(n);
    check("t1_latency", 64'(n + 70 + 2 * DUM), 64'(LAT));
    check("t1_data", 64'(o_data), 64'(24'hA5C33C));
    check("t1_id", 64'(o_data_id), 64'(1'b0));
    check("t1_mosi", 64'(mosi_sr), 64'({OPC, 24'h012345}));
    step(1);
    check("t1_valid_pulse", 64'(o_data_valid), 64'(1'b0));
    step(5);
    check("t1_data_held", 64'(o_data), 64'(24'hA5C33C));

    // Both requesting right after reset
    reset = 1'b1;
    step(1);
    reset   = 1'b0;
    i_addr0 = 24'h111111;
    i_addr1 = 24'h222222;
    i_req   = 2'b11;
    wait_ack(a, n);
    check("t2_first_ack", 64'(a), 64'(2'b01));
    i_req = 2'b10;
    wait_valid(n);
    check("t2_data0", 64'({o_data, o_data_id}), 64'({24'hEEEEEE, 1'b0}));
    wait_ack(a, n);
    check("t2_second_ack", 64'(a), 64'(2'b10));
    check("t2_ack_gap", 64'(n), 64'(2));
    i_req = 2'b00;
    wait_valid(n);
    check("t2_data1", 64'({o_data, o_data_id}), 64'({24'hDDDDDD, 1'b1}));

    // Continuous contention alternates grants
    i_addr0 = 24'h000100;
    i_addr1 = 24'h00FF00;
    i_req   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack(a, n);
      check("t3_ack", 64'(a), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      wait_valid(n);
      check("t3_data", 64'({o_data, o_data_id}),
            (k % 2 == 0) ? 64'({24'hFFFEFF, 1'b0}) : 64'({24'hFF00FF, 1'b1}));
      if (k == 3) i_req = 2'b00;
    end
    step(10);
    check("t3_idle", 64'({o_busy, o_tex_csb}), 64'(2'b01));
    check("t3_csb_gap_ge2", 64'(min_run >= 2), 64'(1'b1));

    // Reset during address bit 10
    i_addr0 = 24'h0ABCDE;
    i_req   = 2'b01;
    wait_ack(a, n);
    check("t4_ack", 64'(a), 64'(2'b01));
    i_req = 2'b00;
    step(43);
    check("t4_mid_addr", 64'({o_busy, o_tex_csb, o_tex_oeb0}), 64'(3'b100));
    vc = valid_cnt;
    reset = 1'b1;
    #1;
    check("t4_async_pins", 64'({o_tex_csb, o_tex_oeb0, o_tex_sclk, o_busy}), 64'(4'b1100));
    check("t4_async_data", 64'({o_data, o_ack}), 64'(0));
    step(2);
    reset = 1'b0;
    step(150);
    check("t4_no_valid", 64'(valid_cnt), 64'(vc));
    i_addr1 = 24'h345678;
    i_req   = 2'b10;
    wait_ack(a, n);
    check("t4_new_ack", 64'(a), 64'(2'b10));
    i_req = 2'b00;
    wait_valid(n);
    check("t4_latency", 64'(n), 64'(LAT));
    check("t4_data", 64'({o_data, o_data_id}), 64'({24'hCBA987, 1'b1}));
    check("t4_mosi", 64'(mosi_sr), 64'({OPC, 24'h345678}));

    // One-cycle request while busy is dropped silently
    step(5);
    a1 = ack1_cnt;
    i_addr0 = 24'h000001;
    i_req   = 2'b01;
    wait_ack(a, n);
    i_req = 2'b00;
    step(20);
    i_req = 2'b10;
    step(1);
    i_req = 2'b00;
    wait_valid(n);
    check("t5_data", 64'({o_data, o_data_id}), 64'({24'hFFFFFE, 1'b0}));
    step(30);
    check("t5_no_ack1", 64'(ack1_cnt), 64'(a1));
    check("t5_idle", 64'({o_busy, o_tex_csb, o_ack}), 64'(4'b0100));

    check("sclk_low_when_csb_high", 64'(viol), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
